eth_rx_fetch: RTL and testbench

AXI read initiator that drains received Ethernet frames out of the Ethernet AXI slave peripheral without CPU involvement. On the peripheral's receive interrupt it reads the protocol type and byte count, then burst-reads the frame data words into a local frame buffer through a simple write port. It sits between the AXI interconnect (master side) and the packet-processing logic that consumes frames from the buffer.

---
 rtl/eth_pkg.sv | 12 +
 rtl/eth_rx_fetch.sv | 114 +++++++++++
 tb/tb_eth_rx_fetch.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: Ethernet RX peripheral register map and the RX fetch FSM state type.
package eth_pkg;
  localparam logic [31:0] RX_PROTOCOL_TYPE = 32'h0000_0014;
  localparam logic [31:0] RX_DATA_COUNT    = 32'h0000_0018;
  localparam logic [31:0] RX_DATA          = 32'h0000_001C;
  typedef enum logic [3:0] {
    IDLE, AR_TYPE, R_TYPE, AR_CNT, R_CNT, AR_DATA, R_DATA, DONE
`ifdef ETH_RX_FETCH_TIMEOUT_EN
    , ERR
`endif
  } fetch_state_t;
endpackage

// File: rtl/eth_rx_fetch.sv
// eth_rx_fetch: AXI read initiator that drains RX frames from the Ethernet peripheral into a frame buffer.
// Define ETH_RX_FETCH_TIMEOUT_EN to add the handshake watchdog, the ERR state and timeout_err.
module eth_rx_fetch
  import eth_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BUF_AW      = 9,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_100_mhz,
  input  logic              rst,
  input  logic              enable,
  input  logic              rx_ready_int,
  output logic [ADDR_W-1:0] m_araddr,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic              m_rvalid,
  input  logic              m_rlast,
  output logic              m_rready,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_addr,
  output logic [31:0]       buf_wdata,
  output logic              frame_done,
  output logic [15:0]       frame_bytes,
  output logic [15:0]       frame_type,
  output logic              overflow,
  output logic              timeout_err,
  output logic              busy
);
  fetch_state_t state, state_next;
  logic [15:0] type_q, cnt_q;
  logic [BUF_AW:0] wcnt;
  logic is_ar, is_r, ar_hs, beat, room, start;
  assign is_ar = state inside {AR_TYPE, AR_CNT, AR_DATA};
  assign is_r  = state inside {R_TYPE, R_CNT, R_DATA};
  assign ar_hs = is_ar & m_arvalid & m_arready;
  assign beat  = is_r & m_rvalid & m_rready;
  assign room  = ~wcnt[BUF_AW];
  assign start = (state == IDLE) & (state_next != IDLE);
`ifdef ETH_RX_FETCH_TIMEOUT_EN
  logic [15:0] wdog;
  logic expired;
  assign expired = (is_ar | is_r) & ~(ar_hs | beat) & (wdog == 16'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk_100_mhz or posedge rst)
    if (rst) begin
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else begin
      wdog        <= ((is_ar | is_r) & ~(ar_hs | beat)) ? wdog + 16'd1 : '0;
      timeout_err <= timeout_err | expired;
    end
`else
  assign timeout_err = (TIMEOUT_CYC < 0);
`endif
  always_ff @(posedge clk_100_mhz or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable & rx_ready_int) state_next = AR_TYPE;
      AR_TYPE: if (ar_hs) state_next = R_TYPE;
      R_TYPE:  if (beat) state_next = AR_CNT;
      AR_CNT:  if (ar_hs) state_next = R_CNT;
      R_CNT:   if (beat) state_next = (m_rdata[15:0] == 16'd0) ? DONE : AR_DATA;
      AR_DATA: if (ar_hs) state_next = R_DATA;
      R_DATA:  if (beat & m_rlast) state_next = DONE;
      default: state_next = IDLE;
    endcase
`ifdef ETH_RX_FETCH_TIMEOUT_EN
    if (expired) state_next = ERR;
`endif
  end
  // valid/ready are registered from the state, so they rise one cycle after entry and drop on the handshake edge
  always_ff @(posedge clk_100_mhz or posedge rst)
    if (rst) begin
      m_araddr    <= '0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      frame_done  <= 1'b0;
      frame_bytes <= '0;
      frame_type  <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      type_q      <= '0;
      cnt_q       <= '0;
      wcnt        <= '0;
    end else begin
      m_arvalid  <= is_ar & (state_next == state);
      m_rready   <= is_r & (state_next == state);
      m_araddr   <= (state_next == AR_TYPE) ? ADDR_W'(RX_PROTOCOL_TYPE) :
                    (state_next == AR_CNT)  ? ADDR_W'(RX_DATA_COUNT) :
                    (state_next == AR_DATA) ? ADDR_W'(RX_DATA) : m_araddr;
      busy       <= state_next != IDLE;
      frame_done <= state_next == DONE;
      type_q     <= (state == R_TYPE) & beat ? m_rdata[15:0] : type_q;
      cnt_q      <= (state == R_CNT) & beat ? m_rdata[15:0] : cnt_q;
      buf_we     <= (state == R_DATA) & beat & room;
      if ((state == R_DATA) & beat & room) begin
        buf_addr  <= wcnt[BUF_AW-1:0];
        buf_wdata <= m_rdata;
      end
      wcnt       <= start ? '0 : wcnt + {{BUF_AW{1'b0}}, (state == R_DATA) & beat & room};
      overflow   <= ~start & (overflow | ((state == R_DATA) & beat & ~room));
      if (state_next == DONE) begin
        frame_bytes <= (state == R_CNT) ? m_rdata[15:0] : cnt_q;
        frame_type  <= type_q;
      end
    end
endmodule

// File: tb/tb_eth_rx_fetch.sv
// tb_eth_rx_fetch: directed frames against a queue model of the expected buffer writes and frame results.
// Uses a 16-word buffer so the overflow case is short; ETH_RX_FETCH_TIMEOUT_EN enables the watchdog case.
`timescale 1ns/1ps
module tb_eth_rx_fetch;
  import eth_pkg::*;
  localparam int BUF_AW = 4;
  localparam int DEPTH  = 16;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, rx_ready_int = 1'b0;
  logic [31:0] m_araddr, m_rdata = '0, buf_wdata;
  logic m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rlast = 1'b0, m_rready;
  logic buf_we, frame_done, overflow, timeout_err, busy;
  logic [BUF_AW-1:0] buf_addr;
  logic [15:0] frame_bytes, frame_type;
  int checks = 0, errors = 0, cyc = 0, wr_total = 0, done_cnt = 0, done_exp = 0;
  logic [BUF_AW-1:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [15:0] exp_bytes = '0, exp_type = '0;
  logic exp_ovf = 1'b0, pend = 1'b0;
  logic [31:0] pend_addr = '0;

  eth_rx_fetch #(.ADDR_W(32), .BUF_AW(BUF_AW), .TIMEOUT_CYC(32)) dut (
    .clk_100_mhz(clk), .rst(rst), .enable(enable), .rx_ready_int(rx_ready_int),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .frame_done(frame_done), .frame_bytes(frame_bytes), .frame_type(frame_type),
    .overflow(overflow), .timeout_err(timeout_err), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input int f, input int i);
    return {8'(f), 8'h5A, 16'(i * 37 + 1)};
  endfunction

  // Compare process: AR stability, every buffer write, and every frame_done against the model.
  always @(negedge clk) begin
    if (rst) pend <= 1'b0;
    else begin
      if (pend) begin
        chk("arvalid_hold", 32'(m_arvalid), 32'd1);
        chk("araddr_hold", m_araddr, pend_addr);
      end
      pend      <= m_arvalid & ~m_arready;
      pend_addr <= m_araddr;
      if (buf_we) begin
        wr_total <= wr_total + 1;
        if (exp_a.size() == 0) chk("unexpected_write", 32'(buf_addr), 32'hFFFF_FFFF);
        else begin
          chk("buf_addr", 32'(buf_addr), 32'(exp_a[0]));
          chk("buf_wdata", buf_wdata, exp_d[0]);
          void'(exp_a.pop_front());
          void'(exp_d.pop_front());
        end
      end
      if (frame_done) begin
        done_cnt <= done_cnt + 1;
        if (done_cnt >= done_exp) chk("spurious_frame_done", 32'd1, 32'd0);
        else begin
          chk("frame_bytes", 32'(frame_bytes), 32'(exp_bytes));
          chk("frame_type", 32'(frame_type), 32'(exp_type));
          chk("overflow", 32'(overflow), 32'(exp_ovf));
          chk("writes_missing", 32'(exp_a.size()), 32'd0);
          chk("timeout_err_at_done", 32'(timeout_err), 32'd0);
        end
      end
    end
  end

  task automatic do_ar(input int dly, output logic [31:0] a);
    int n = 0;
    while (!m_arvalid && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("ar_wait_bound", 32'd0, 32'd1);
    repeat (dly) begin @(posedge clk); #1; end
    m_arready = 1'b1;
    a = m_araddr;
    @(posedge clk); #1;
    m_arready = 1'b0;
  endtask

  task automatic do_beat(input logic [31:0] d, input logic last, input int gap, input logic held);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    if (held) chk("rready_held", 32'(m_rready), 32'd1);
    m_rvalid = 1'b1; m_rdata = d; m_rlast = last;
    while (!m_rready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) chk("r_wait_bound", 32'd0, 32'd1);
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  // cut >= 0 stops after that many data beats and expects no frame_done
  task automatic run_frame(input int f, input logic [15:0] typ, input logic [15:0] bytes, input int nb,
                           input int dly, input int gap, input int cut, input logic drop_en, output int lat);
    logic [31:0] a;
    int t0, n;
    lat = -1;
    for (int i = 0; i < nb && i < DEPTH; i++) begin
      exp_a.push_back(BUF_AW'(i));
      exp_d.push_back(dat(f, i));
    end
    exp_type = typ; exp_bytes = bytes; exp_ovf = nb > DEPTH;
    if (cut < 0) done_exp++;
    t0 = cyc;
    rx_ready_int = 1'b1;
    do_ar(dly, a);
    rx_ready_int = 1'b0;
    if (drop_en) enable = 1'b0;
    chk("ar_type_addr", a, RX_PROTOCOL_TYPE);
    do_beat({16'hDEAD, typ}, 1'b1, gap, 1'b0);
    do_ar(dly, a);
    chk("ar_cnt_addr", a, RX_DATA_COUNT);
    do_beat({16'hBEEF, bytes}, 1'b1, gap, 1'b0);
    if (nb > 0) begin
      do_ar(dly, a);
      chk("ar_data_addr", a, RX_DATA);
      for (int i = 0; i < nb && (cut < 0 || i < cut); i++) do_beat(dat(f, i), i == nb - 1, gap, i > 0);
    end
    if (cut < 0) begin
      n = 0;
      while (!frame_done && n < 300) begin @(negedge clk); n++; end
      chk("frame_done_seen", 32'(frame_done), 32'd1);
      lat = cyc - t0;
      @(posedge clk); #1;
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("arvalid_after_done", 32'(m_arvalid), 32'd0);
      enable = 1'b1;
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_m_arvalid"}, 32'(m_arvalid), 32'd0);
    chk({p, "_m_rready"}, 32'(m_rready), 32'd0);
    chk({p, "_m_araddr"}, m_araddr, 32'd0);
    chk({p, "_buf_we"}, 32'(buf_we), 32'd0);
    chk({p, "_buf_addr"}, 32'(buf_addr), 32'd0);
    chk({p, "_buf_wdata"}, buf_wdata, 32'd0);
    chk({p, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({p, "_frame_bytes"}, 32'(frame_bytes), 32'd0);
    chk({p, "_frame_type"}, 32'(frame_type), 32'd0);
    chk({p, "_overflow"}, 32'(overflow), 32'd0);
    chk({p, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({p, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, w0, t0, n;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    w0 = wr_total;
    run_frame(1, 16'h0800, 16'd64, 16, 0, 0, -1, 1'b0, lat);
    chk("f1_writes", 32'(wr_total - w0), 32'd16);
    chk("f1_bytes_lit", 32'(frame_bytes), 32'd64);
    chk("f1_type_lit", 32'(frame_type), 32'h0800);
    w0 = wr_total;
    run_frame(2, 16'h0800, 16'd64, 16, 5, 3, -1, 1'b1, lat);
    chk("f2_writes", 32'(wr_total - w0), 32'd16);
    chk("f2_no_overflow", 32'(overflow), 32'd0);
    w0 = wr_total;
    run_frame(3, 16'h86DD, 16'd80, 20, 0, 1, -1, 1'b0, lat);
    chk("f3_writes", 32'(wr_total - w0), 32'd16);
    chk("f3_overflow_lit", 32'(overflow), 32'd1);
    w0 = wr_total;
    run_frame(4, 16'h0806, 16'd0, 0, 0, 0, -1, 1'b0, lat);
    chk("f4_latency", 32'(lat), 32'd9);
    chk("f4_bytes_lit", 32'(frame_bytes), 32'd0);
    chk("f4_writes", 32'(wr_total - w0), 32'd0);
    chk("f4_overflow_cleared", 32'(overflow), 32'd0);
    run_frame(5, 16'h0800, 16'd64, 16, 0, 0, 7, 1'b0, lat);
    @(negedge clk); #1;
    rst = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
    #1;
    check_reset("mid");
    chk("mid_writes_left", 32'(exp_a.size()), 32'd9);
    exp_a.delete(); exp_d.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    w0 = wr_total;
    run_frame(6, 16'h0800, 16'd30, 8, 2, 1, -1, 1'b0, lat);
    chk("f6_writes", 32'(wr_total - w0), 32'd8);
    chk("f6_bytes_lit", 32'(frame_bytes), 32'd30);
    enable = 1'b0; rx_ready_int = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("disabled_busy", 32'(busy), 32'd0);
    chk("disabled_arvalid", 32'(m_arvalid), 32'd0);
    rx_ready_int = 1'b0; enable = 1'b1;
`ifdef ETH_RX_FETCH_TIMEOUT_EN
    rx_ready_int = 1'b1;
    do_ar(0, a);
    rx_ready_int = 1'b0;
    do_beat({16'h0, 16'h0800}, 1'b1, 0, 1'b0);
    do_ar(0, a);
    t0 = cyc; n = 0;
    while (!timeout_err && n < 100) begin @(negedge clk); n++; end
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_latency", 32'(cyc - t0), 32'd32);
    repeat (3) begin @(posedge clk); #1; end
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_rready", 32'(m_rready), 32'd0);
    chk("timeout_sticky", 32'(timeout_err), 32'd1);
`else
    a = '0; t0 = 0; n = 0;
    chk("timeout_tied", 32'(timeout_err), 32'd0);
`endif
    repeat (4) @(posedge clk);
    #1;
    chk("frames_done_total", 32'(done_cnt), 32'(done_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
